clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 32: counter and limit width in bits.
REQ-003 Parameter SYS_FREQ, default 50000000: clkin frequency in Hz.
REQ-004 Parameter DEF_FREQ, default 1000: output frequency every channel takes after reset.
REQ-005 Port clkin, input, 1: sole clock; all logic is rising-edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port clken, input, 1: global count enable, qualifies every channel.
REQ-008 Port ch_en, input, NCH: per-channel count enable.
REQ-009 Port wr_en, input, 1: configuration write strobe.
REQ-010 Port wr_ch, input, 4: target channel of the write.
REQ-011 Port wr_lim, input, CNT_W: new half-period limit.
REQ-012 Port wr_mode, input, 1: new mode (0 = SQUARE, 1 = PULSE).
REQ-013 Port rd_ch, input, 4: channel selected for readback.
REQ-014 Port rd_lim, output, CNT_W: registered limit of channel rd_ch.
REQ-015 Port clkout, output, NCH: per-channel divided output.
REQ-016 Port tick, output, NCH: per-channel single-cycle terminal-count strobe.

Function
REQ-017 Each channel c holds lim[c], mode[c], cnt[c], clkout[c] and tick[c]; all are registered.
REQ-018 Active cycle for channel c means clken=1 and ch_en[c]=1.
REQ-019 In an active cycle, when cnt+1 >= eff_lim the counter loads 0 and a terminal event occurs; otherwise cnt increments.
REQ-020 eff_lim equals lim, except lim=0, which is treated as 1.
REQ-021 A terminal event drives tick[c]=1 for exactly the next clkin cycle; tick[c] is 0 in every other cycle.
REQ-022 In SQUARE mode, clkout[c] toggles on each terminal event, so the period is 2*eff_lim active cycles.
REQ-023 In PULSE mode, clkout[c] equals tick[c].
REQ-024 In an inactive cycle, cnt[c] and clkout[c] (SQUARE mode) hold their values and tick[c]=0.
REQ-025 Write with wr_en=1 and wr_ch<NCH: at the next edge, lim, mode, cnt, clkout and tick of that channel load wr_lim, wr_mode, 0, 0 and 0.
REQ-026 Write with wr_ch>=NCH is ignored and has no side effects.
REQ-027 Write and terminal event on the same channel in the same cycle: the write wins; no toggle and no tick.
REQ-028 A write to one channel does not disturb any other channel.
REQ-029 rd_lim shows lim[rd_ch] one cycle after rd_ch is presented, including a limit written in that same cycle.
REQ-030 rd_ch>=NCH returns 0.

Reset
REQ-031 While rst=1, asynchronously: lim = SYS_FREQ/2/DEF_FREQ, mode = SQUARE, cnt = 0, clkout = 0, tick = 0, rd_lim = 0.
REQ-032 A reset in mid-count abandons the count; the first terminal event after release occurs eff_lim active cycles later.

Structure
REQ-033 Package clk_div_pkg holds the MODE_SQUARE/MODE_PULSE encodings and the DEF_LIM computation function.
REQ-034 Sub-module clk_div_ch implements one channel (counter, limit, mode, outputs) and is instantiated NCH times.
REQ-035 Write decode and readback mux live in the top level.

Verification
REQ-036 Reset, then hold clken=1 and ch_en=4'hF with defaults -> clkout[0] toggles every 25000 cycles and tick[0] pulses every 25000 cycles.
REQ-037 Write ch1 with lim=3, mode=SQUARE -> clkout[1] has period 6 cycles, 50% duty; ch0, ch2 and ch3 are unaffected.
REQ-038 Write ch2 with lim=4, mode=PULSE -> clkout[2] is high for 1 cycle in every 4; lim=0 gives a constant 1 on tick[2].
REQ-039 Toggle clken low for 5 cycles mid-count on ch1 (lim=3) -> outputs freeze, then resume with the period stretched by exactly 5 cycles.
REQ-040 Write ch1 in the cycle of its terminal count -> no toggle or tick, cnt=0; a write with wr_ch=9 changes nothing.
REQ-041 Assert rst asynchronously between edges mid-count -> all outputs are 0 immediately, and rd_lim of ch3 returns 25000 after release.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_bank shared types: output mode encodings and reset limit helper.
package clk_div_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // Half-period in clkin cycles for a requested output frequency
    function automatic longint def_lim(longint sys_freq, longint def_freq);
        if (def_freq == 0)
            return 1;
        return sys_freq / 2 / def_freq;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration write / limit readback bus of clk_div_bank.
interface clk_div_bank_if #(
    parameter int CNT_W = 32
);
    logic             wr_en;
    logic [3:0]       wr_ch;
    logic [CNT_W-1:0] wr_lim;
    logic             wr_mode;
    logic [3:0]       rd_ch;
    logic [CNT_W-1:0] rd_lim;

    modport master (
        output wr_en, wr_ch, wr_lim, wr_mode, rd_ch,
        input  rd_lim
    );

    modport slave (
        input  wr_en, wr_ch, wr_lim, wr_mode, rd_ch,
        output rd_lim
    );
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: limit/mode registers, counter, clkout and tick.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int               CNT_W   = 32,
    parameter logic [CNT_W-1:0] RST_LIM = '0
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             active,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_lim,
    input  mode_e            wr_mode,
    output logic [CNT_W-1:0] lim,
    output logic             clkout,
    output logic             tick
);

    mode_e            mode;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_lim;
    logic [CNT_W:0]   cnt_inc;
    logic             term;

    // A zero limit behaves like 1 so the channel never stalls
    assign eff_lim = (lim == '0) ? CNT_W'(1) : lim;
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
    assign term    = active && (cnt_inc >= {1'b0, eff_lim});

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            lim    <= RST_LIM;
            mode   <= MODE_SQUARE;
            cnt    <= '0;
            clkout <= 1'b0;
            tick   <= 1'b0;
        end else if (wr) begin
            lim    <= wr_lim;
            mode   <= wr_mode;
            cnt    <= '0;
            clkout <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= term;
            if (active)
                cnt <= term ? '0 : cnt_inc[CNT_W-1:0];
            if (mode == MODE_PULSE)
                clkout <= term;
            else if (term)
                clkout <= ~clkout;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers with write decode and limit readback.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CNT_W    = 32,
    parameter int SYS_FREQ = 50000000,
    parameter int DEF_FREQ = 1000
) (
    input  logic           clkin,
    input  logic           rst,
    input  logic           clken,
    input  logic [NCH-1:0] ch_en,
    clk_div_bank_if.slave  cfg,
    output logic [NCH-1:0] clkout,
    output logic [NCH-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_LIM =
        CNT_W'(def_lim(SYS_FREQ, DEF_FREQ));

    logic [CNT_W-1:0] lim [NCH];
    logic [NCH-1:0]   wr_sel;
    logic [CNT_W-1:0] rd_nxt;

    // Out-of-range channels never match, so such writes and reads fall through
    always_comb begin
        wr_sel = '0;
        rd_nxt = '0;
        for (int c = 0; c < NCH; c++) begin
            if (cfg.wr_en && cfg.wr_ch == 4'(c))
                wr_sel[c] = 1'b1;
            if (cfg.rd_ch == 4'(c))
                rd_nxt = wr_sel[c] ? cfg.wr_lim : lim[c];
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst)
            cfg.rd_lim <= '0;
        else
            cfg.rd_lim <= rd_nxt;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W   (CNT_W),
            .RST_LIM (DEF_LIM)
        ) u_ch (
            .clkin   (clkin),
            .rst     (rst),
            .active  (clken & ch_en[g]),
            .wr      (wr_sel[g]),
            .wr_lim  (cfg.wr_lim),
            .wr_mode (mode_e'(cfg.wr_mode)),
            .lim     (lim[g]),
            .clkout  (clkout[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank.
module tb_clk_div_bank;

    localparam int NCH   = 4;
    localparam int CNT_W = 32;

    logic           clkin = 1'b0;
    logic           rst;
    logic           clken;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] clkout;
    logic [NCH-1:0] tick;

    int          nchk = 0;
    int          nerr = 0;
    int          n;
    logic [13:0] cv;
    logic [13:0] tv;
    logic        frz;

    clk_div_bank_if #(.CNT_W(CNT_W)) cfg ();

    clk_div_bank #(
        .NCH      (NCH),
        .CNT_W    (CNT_W),
        .SYS_FREQ (50000000),
        .DEF_FREQ (1000)
    ) dut (
        .clkin  (clkin),
        .rst    (rst),
        .clken  (clken),
        .ch_en  (ch_en),
        .cfg    (cfg),
        .clkout (clkout),
        .tick   (tick)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] ch, input logic [31:0] lim,
                      input logic mode);
        cfg.wr_en   = 1'b1;
        cfg.wr_ch   = ch;
        cfg.wr_lim  = lim;
        cfg.wr_mode = mode;
        @(negedge clkin);
        cfg.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] ch, input logic [31:0] exp,
                      input string tag);
        cfg.rd_ch = ch;
        @(negedge clkin);
        chk(tag, cfg.rd_lim, exp);
    endtask

    task automatic wait_tick0(input int max, output int cnt);
        cnt = 0;
        do begin
            @(negedge clkin);
            cnt++;
        end while (!tick[0] && cnt < max);
    endtask

    initial begin
        rst         = 1'b1;
        clken       = 1'b0;
        ch_en       = '0;
        cfg.wr_en   = 1'b0;
        cfg.wr_ch   = '0;
        cfg.wr_lim  = '0;
        cfg.wr_mode = 1'b0;
        cfg.rd_ch   = 4'd3;
        repeat (2) @(negedge clkin);
        chk("rst_clkout", 32'(clkout), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_rdlim", cfg.rd_lim, 0);

        // default limit 25000: first terminal event on the 25000th edge
        rst   = 1'b0;
        clken = 1'b1;
        ch_en = 4'hF;
        wait_tick0(30000, n);
        chk("ch0_first", 32'(n), 25000);
        chk("all_tick", 32'(tick), 32'hF);
        chk("ch0_clk_hi", 32'(clkout[0]), 1);
        chk("def_rdlim", cfg.rd_lim, 25000);
        wait_tick0(30000, n);
        chk("ch0_period", 32'(n), 25000);
        chk("ch0_clk_lo", 32'(clkout[0]), 0);

        // ch1 square, lim 3: period 6
        wr(4'd1, 3, 1'b0);
        cv = '0;
        tv = '0;
        frz = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cv[k] = clkout[1];
            tv[k] = tick[1];
            frz   = frz | tick[0] | tick[2] | tick[3];
            @(negedge clkin);
        end
        chk("sq_clk", 32'(cv[11:0]), 32'hE38);
        chk("sq_tick", 32'(tv[11:0]), 32'h248);
        chk("sq_others_tick", 32'(frz), 0);
        chk("sq_others_clk", 32'({clkout[3], clkout[2], clkout[0]}), 0);

        // ch2 pulse, lim 4
        wr(4'd2, 4, 1'b1);
        cv = '0;
        tv = '0;
        for (int k = 0; k < 12; k++) begin
            cv[k] = clkout[2];
            tv[k] = tick[2];
            @(negedge clkin);
        end
        chk("pl_clk", 32'(cv[11:0]), 32'h110);
        chk("pl_tick", 32'(tv[11:0]), 32'h110);

        // lim 0 behaves as 1: tick every cycle
        wr(4'd2, 0, 1'b1);
        cv = '0;
        tv = '0;
        for (int k = 0; k < 9; k++) begin
            cv[k] = clkout[2];
            tv[k] = tick[2];
            @(negedge clkin);
        end
        chk("lim0_tick", 32'(tv[8:0]), 32'h1FE);
        chk("lim0_clk", 32'(cv[8:0]), 32'h1FE);

        // clken low for 5 cycles stretches ch1 by exactly 5
        wr(4'd1, 3, 1'b0);
        cv = '0;
        tv = '0;
        frz = 1'b0;
        for (int k = 0; k < 14; k++) begin
            cv[k] = clkout[1];
            tv[k] = tick[1];
            if (k == 3)
                frz = tick[2];
            clken = (k < 1 || k >= 6);
            @(negedge clkin);
        end
        chk("frz_clk", 32'(cv), 32'h0700);
        chk("frz_tick", 32'(tv), 32'h0900);
        chk("frz_tick2", 32'(frz), 0);

        // write lands on the terminal-count edge
        wr(4'd1, 3, 1'b0);
        repeat (2) @(negedge clkin);
        wr(4'd1, 3, 1'b0);
        chk("wrterm_clk", 32'(clkout[1]), 0);
        chk("wrterm_tick", 32'(tick[1]), 0);
        repeat (2) @(negedge clkin);
        chk("wrterm_k5", 32'(clkout[1]), 0);
        @(negedge clkin);
        chk("wrterm_k6_clk", 32'(clkout[1]), 1);
        chk("wrterm_k6_tick", 32'(tick[1]), 1);
        wr(4'd9, 7, 1'b1);
        repeat (2) @(negedge clkin);
        chk("bad_wr_clk", 32'(clkout[1]), 0);
        chk("bad_wr_tick", 32'(tick[1]), 1);

        rd(4'd0, 25000, "rd_ch0");
        rd(4'd1, 3, "rd_ch1");
        rd(4'd2, 0, "rd_ch2");
        rd(4'd3, 25000, "rd_ch3");
        rd(4'd9, 0, "rd_ch9");
        cfg.rd_ch = 4'd3;
        wr(4'd3, 77, 1'b0);
        chk("rd_bypass", cfg.rd_lim, 77);

        // asynchronous reset between edges
        chk("pre_rst_clk2", 32'(clkout[2]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_clkout", 32'(clkout), 0);
        chk("async_tick", 32'(tick), 0);
        chk("async_rdlim", cfg.rd_lim, 0);
        @(negedge clkin);
        rst = 1'b0;
        @(negedge clkin);
        chk("post_rst_rd3", cfg.rd_lim, 25000);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
